req_gnt_slave_fifo: RTL and testbench
=====================================

// Module: req_gnt_slave_fifo
// PURPOSE
//  Responder end of the req/gnt/data master-slave interface. Issues gnt to a requesting master
//  only while buffer space exists, and captures data on every req&&gnt cycle into a FIFO.
//  The local consumer drains the FIFO first-word-fall-through. Sits between the master and the
//  downstream consumer, replacing the always-grant slave with a flow-controlled one.
// PARAMETERS
//  DW     8  data width of the data bus and FIFO entries
//  DEPTH  4  FIFO entries; power of 2, >=2
//  AW     $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       asynchronous active-high reset
//  req        in   1       master request / data-valid
//  data       in   DW      master data, sampled when req&&gnt at posedge
//  gnt        out  1       registered grant to master
//  rd_en      in   1       consumer pop request
//  rd_data    out  DW      head entry (FWFT); 0 when empty
//  empty      out  1       FIFO empty
//  full       out  1       FIFO full (count==DEPTH)
//  count      out  AW+1    entries held, 0..DEPTH
// BEHAVIOUR
//  Reset (async, rst=1): gnt=0, count=0, empty=1, full=0, wr/rd ptrs=0, state=IDLE, rd_data=0.
//   Reset mid-transfer discards all FIFO contents and any in-flight beat; no write on that edge.
//  Transfer: write when req&&gnt at posedge -> mem[wr_ptr]<=data, wr_ptr++ (wraps mod DEPTH).
//  Pop: rd_en&&!empty at posedge -> rd_ptr++ (wraps). rd_en while empty ignored, count stays 0.
//  count_nxt = count + wr - pop; simultaneous write and pop -> count unchanged, both ptrs advance.
//  Grant rule (registered, 1-cycle latency): gnt <= req && (count_nxt < DEPTH).
//   => a write never hits a full FIFO; no overflow and no data loss by construction.
//   => master sees gnt at earliest one cycle after first asserting req.
//  Pop frees a slot same edge: full FIFO with rd_en and req -> gnt=1 next cycle.
//  FSM (3 states, drives gnt):
//   IDLE : gnt=0. req&&room -> GRANT; req&&!room -> STALL; else IDLE.
//   GRANT: gnt=1. !req -> IDLE; req&&!room -> STALL; else GRANT.
//   STALL: gnt=0. !req -> IDLE; req&&room -> GRANT; else STALL.
//   room = (count_nxt < DEPTH). gnt is 1 exactly when state==GRANT.
//  Outputs empty/full/count are registered-consistent with count; rd_data combinational from
//   mem[rd_ptr], forced 0 when empty.
// CONFIGURATION
//  RGS_STATS_EN defined: adds outputs xfer_cnt[15:0] (req&&gnt cycles) and stall_cnt[15:0]
//   (cycles in STALL); both saturate at 16'hFFFF, reset to 0 by rst.
//  Not defined: ports and counters absent; core behaviour identical.
// TESTING
//  1 Reset: rst=1 with req=1 -> gnt=0, empty=1, count=0; release rst -> gnt=1 one cycle later.
//  2 Burst 4 beats 8'h11,22,33,44, rd_en=0 (DEPTH=4) -> 4 writes, full=1, gnt drops to 0 the
//    cycle after 4th write-edge, state STALL; 5th value 8'h55 held by master, not written.
//  3 From full, pulse rd_en 1 cycle -> rd_data was 8'h11, next head 8'h22, gnt=1 next cycle,
//    8'h55 written; count back to 4, no overflow.
//  4 Continuous req and rd_en, 20 random beats -> output order equals input order, count
//    stable, gnt never drops, ptr wrap exercised.
//  5 rd_en with empty=1 -> count stays 0, rd_data=0; req=0 in GRANT -> IDLE, gnt=0 next cycle.
//  6 Async rst asserted between edges with count=3 -> all outputs reset immediately;
//    with RGS_STATS_EN, after scenario 2 xfer_cnt=4 and stall_cnt = cycles spent in STALL.

Source files
------------

// File: rtl/req_gnt_slave_fifo.sv
// Flow-controlled responder for the req/gnt/data interface with a first-word-fall-through FIFO.
// Optional statistics counters (xfer_cnt, stall_cnt) are built when RGS_STATS_EN is defined.
module req_gnt_slave_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [DW-1:0] data,
  output logic          gnt,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
`ifdef RGS_STATS_EN
  ,
  output logic [15:0]   xfer_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  localparam logic [AW:0] DepthVal = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic            wr;
  logic            pop;
  logic            room;

  assign gnt     = (state_q == GRANT);
  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthVal);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  assign wr   = req && gnt;
  assign pop  = rd_en && !empty;

  // Grant decision looks at the post-edge occupancy, so a pop on this edge frees room at once.
  always_comb begin
    count_d  = count_q + (AW+1)'(wr) - (AW+1)'(pop);
    wr_ptr_d = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    room     = (count_d < DepthVal);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = room ? GRANT : STALL;
      end
      GRANT: begin
        if (!req)      state_d = IDLE;
        else if (!room) state_d = STALL;
      end
      STALL: begin
        if (!req)     state_d = IDLE;
        else if (room) state_d = GRANT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= data;
  end

`ifdef RGS_STATS_EN
  logic [15:0] xfer_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (wr && xfer_cnt_q != 16'hFFFF) xfer_cnt_q <= xfer_cnt_q + 16'd1;
      if (state_q == STALL && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign xfer_cnt  = xfer_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_req_gnt_slave_fifo.sv
// Directed self-checking bench for req_gnt_slave_fifo (DW=8, DEPTH=4).
// Covers reset, burst-to-full, pop-unblocks-grant, streaming order, empty pops and async reset.
module tb_req_gnt_slave_fifo;

  logic       clk;
  logic       rst;
  logic       req;
  logic [7:0] data;
  logic       gnt;
  logic       rdEn;
  logic [7:0] rdData;
  logic       empty;
  logic       full;
  logic [2:0] count;
`ifdef RGS_STATS_EN
  logic [15:0] xferCnt;
  logic [15:0] stallCnt;
`endif

  int testsRun;
  int testsFailed;
  logic [7:0] model[$];
  logic [7:0] burstVals[4];

  req_gnt_slave_fifo #(.DW(8), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .data(data),
    .gnt(gnt),
    .rd_en(rdEn),
    .rd_data(rdData),
    .empty(empty),
    .full(full),
    .count(count)
`ifdef RGS_STATS_EN
    ,
    .xfer_cnt(xferCnt),
    .stall_cnt(stallCnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends even if something locks up.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compares one observed value with its expected value and counts the comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advances one clock and settles just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    burstVals[0] = 8'h11;
    burstVals[1] = 8'h22;
    burstVals[2] = 8'h33;
    burstVals[3] = 8'h44;

    // Reset held with an active request: no grant may appear.
    rst  = 1'b1;
    req  = 1'b1;
    rdEn = 1'b0;
    data = 8'h00;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_gnt",    32'(gnt),    32'd0);
    checkOutput("rst_empty",  32'(empty),  32'd1);
    checkOutput("rst_full",   32'(full),   32'd0);
    checkOutput("rst_count",  32'(count),  32'd0);
    checkOutput("rst_rddata", 32'(rdData), 32'd0);

    rst = 1'b0;
    applyStimulus();
    checkOutput("post_rst_gnt", 32'(gnt), 32'd1);

    // Four-beat burst fills the FIFO; grant falls right after the fourth write.
    for (int i = 0; i < 4; i++) begin
      data = burstVals[i];
      applyStimulus();
      checkOutput($sformatf("burst_count%0d", i), 32'(count), 32'(i + 1));
    end
    checkOutput("burst_full", 32'(full), 32'd1);
    checkOutput("burst_gnt",  32'(gnt),  32'd0);

    data = 8'h55;
    applyStimulus();
    checkOutput("stall_count", 32'(count),  32'd4);
    checkOutput("stall_gnt",   32'(gnt),    32'd0);
    checkOutput("stall_head",  32'(rdData), 32'h11);
`ifdef RGS_STATS_EN
    checkOutput("stats_xfer",  32'(xferCnt),  32'd4);
    checkOutput("stats_stall", 32'(stallCnt), 32'd1);
`endif

    // One pop frees a slot; the held 8'h55 goes in on the following edge.
    rdEn = 1'b1;
    applyStimulus();
    rdEn = 1'b0;
    checkOutput("pop_head",  32'(rdData), 32'h22);
    checkOutput("pop_gnt",   32'(gnt),    32'd1);
    checkOutput("pop_count", 32'(count),  32'd3);
    applyStimulus();
    checkOutput("refill_count", 32'(count), 32'd4);
    checkOutput("refill_gnt",   32'(gnt),   32'd0);
    checkOutput("refill_full",  32'(full),  32'd1);

    // Streaming: req and rd_en held, output order must match input order.
    model.push_back(8'h22);
    model.push_back(8'h33);
    model.push_back(8'h44);
    model.push_back(8'h55);
    rdEn = 1'b1;
    checkOutput("stream_head0", 32'(rdData), 32'(model[0]));
    applyStimulus();
    void'(model.pop_front());
    checkOutput("stream_gnt0",   32'(gnt),   32'd1);
    checkOutput("stream_count0", 32'(count), 32'd3);
    for (int i = 0; i < 20; i++) begin
      data = 8'($urandom_range(0, 255));
      checkOutput($sformatf("stream_head%0d", i + 1), 32'(rdData), 32'(model[0]));
      model.push_back(data);
      applyStimulus();
      void'(model.pop_front());
      checkOutput($sformatf("stream_gnt%0d", i + 1),   32'(gnt),   32'd1);
      checkOutput($sformatf("stream_count%0d", i + 1), 32'(count), 32'd3);
    end

    // Dropping req while granted returns to IDLE with no write.
    req  = 1'b0;
    rdEn = 1'b0;
    applyStimulus();
    checkOutput("idle_gnt",   32'(gnt),   32'd0);
    checkOutput("idle_count", 32'(count), 32'd3);

    // Drain the remaining entries, then pop while empty.
    rdEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("drain_head%0d", i), 32'(rdData), 32'(model[0]));
      applyStimulus();
      void'(model.pop_front());
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_count", 32'(count), 32'd0);
    applyStimulus();
    checkOutput("empty_pop_count",  32'(count),  32'd0);
    checkOutput("empty_pop_rddata", 32'(rdData), 32'd0);
    checkOutput("empty_pop_empty",  32'(empty),  32'd1);

    // Refill three entries, then assert reset between edges.
    rdEn = 1'b0;
    req  = 1'b1;
    applyStimulus();
    checkOutput("refill3_gnt", 32'(gnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      data = 8'hA0 + 8'(i);
      applyStimulus();
    end
    checkOutput("pre_arst_count", 32'(count),  32'd3);
    checkOutput("pre_arst_head",  32'(rdData), 32'hA0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_count",  32'(count),  32'd0);
    checkOutput("arst_gnt",    32'(gnt),    32'd0);
    checkOutput("arst_empty",  32'(empty),  32'd1);
    checkOutput("arst_full",   32'(full),   32'd0);
    checkOutput("arst_rddata", 32'(rdData), 32'd0);
`ifdef RGS_STATS_EN
    checkOutput("arst_xfer",  32'(xferCnt),  32'd0);
    checkOutput("arst_stall", 32'(stallCnt), 32'd0);
`endif
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    checkOutput("post_arst_count", 32'(count), 32'd0);
    checkOutput("post_arst_gnt",   32'(gnt),   32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
